// File: rtl/matrix_addsub_stream_if.sv
// Bundle of job-control, source-read and destination-write signals for
// matrix_addsub_stream. The engine uses the slave side; the host / memory
// side uses the master side.
interface matrix_addsub_stream_if #(
  parameter int DATA_W = 32,
  parameter int DIM_W  = 8
);
  // job control
  logic                     start;
  logic [1:0]               op;
  logic [DIM_W-1:0]         m_dim;
  logic [DIM_W-1:0]         n_dim;
  logic                     busy;
  logic                     done;
  logic                     err;
  logic                     ovf;
  // source memory read port (shared by A and B)
  logic                     rd_en;
  logic [DIM_W-1:0]         rd_row;
  logic [DIM_W-1:0]         rd_col;
  logic signed [DATA_W-1:0] a_data;
  logic signed [DATA_W-1:0] b_data;
  // destination memory write port
  logic                     wr_en;
  logic [DIM_W-1:0]         wr_row;
  logic [DIM_W-1:0]         wr_col;
  logic signed [DATA_W-1:0] wr_data;
  logic                     wr_ready;

  modport slave (
    input  start, op, m_dim, n_dim, a_data, b_data, wr_ready,
    output busy, done, err, ovf, rd_en, rd_row, rd_col,
           wr_en, wr_row, wr_col, wr_data
  );

  modport master (
    output start, op, m_dim, n_dim, a_data, b_data, wr_ready,
    input  busy, done, err, ovf, rd_en, rd_row, rd_col,
           wr_en, wr_row, wr_col, wr_data
  );
endinterface

// File: rtl/matrix_addsub_stream.sv
// matrix_addsub_stream: walks A and B in row-major order and streams
// C = op(A, B) to the destination memory. Three stages: read issue, compute
// from the returned data, output register. A one-entry skid register catches
// the single read that can be in flight when the destination stalls.
module matrix_addsub_stream #(
  parameter int DATA_W = 32,
  parameter int DIM_W  = 8,
  parameter bit SAT    = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  matrix_addsub_stream_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [DIM_W-1:0]  DIM_ONE  = DIM_W'(1);
  localparam logic [DIM_W-1:0]  DIM_ZERO = '0;
  localparam logic [DATA_W-1:0] DATA_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] DATA_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  // control state
  state_t            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [DIM_W-1:0]  m_dim_q, m_dim_d;
  logic [DIM_W-1:0]  n_dim_q, n_dim_d;
  logic [DIM_W-1:0]  row_q, row_d;
  logic [DIM_W-1:0]  col_q, col_d;
  logic              err_q, err_d;
  logic              ovf_q, ovf_d;

  // stage 2: address of the element whose data is on a_data/b_data
  logic              s1_valid_q, s1_valid_d;
  logic [DIM_W-1:0]  s1_row_q, s1_row_d;
  logic [DIM_W-1:0]  s1_col_q, s1_col_d;

  // skid register
  logic              skid_valid_q, skid_valid_d;
  logic [DIM_W-1:0]  skid_row_q, skid_row_d;
  logic [DIM_W-1:0]  skid_col_q, skid_col_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;

  // output register driving the write port
  logic              out_valid_q, out_valid_d;
  logic [DIM_W-1:0]  out_row_q, out_row_d;
  logic [DIM_W-1:0]  out_col_q, out_col_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;

  logic              stall;
  logic              rd_en;
  logic              overflow;
  logic [DATA_W-1:0] result;
  logic signed [DATA_W:0] a_ext, b_ext, wide, avg;

  assign stall = out_valid_q && !bus.wr_ready;
  assign rd_en = (state_q == RUN) && !stall;

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM next state, job latching, address walk and status flags
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    m_dim_d = m_dim_q;
    n_dim_d = n_dim_q;
    row_d   = row_q;
    col_d   = col_q;
    err_d   = err_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.m_dim == DIM_ZERO || bus.n_dim == DIM_ZERO) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            err_d   = 1'b0;
            ovf_d   = 1'b0;
            op_d    = bus.op;
            m_dim_d = bus.m_dim;
            n_dim_d = bus.n_dim;
            row_d   = DIM_ZERO;
            col_d   = DIM_ZERO;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (rd_en) begin
          if (col_q == n_dim_q - DIM_ONE) begin
            col_d = DIM_ZERO;
            if (row_q == m_dim_q - DIM_ONE) begin
              row_d   = DIM_ZERO;
              state_d = DRAIN;
            end else begin
              row_d = row_q + DIM_ONE;
            end
          end else begin
            col_d = col_q + DIM_ONE;
          end
        end
      end
      DRAIN: begin
        if (!s1_valid_q && !skid_valid_q && (!out_valid_q || bus.wr_ready))
          state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (s1_valid_q && overflow) ovf_d = 1'b1;
  end

  // Element arithmetic at DATA_W+1 bits with saturate or wrap on overflow
  always_comb begin
    a_ext    = {bus.a_data[DATA_W-1], bus.a_data};
    b_ext    = {bus.b_data[DATA_W-1], bus.b_data};
    wide     = '0;
    avg      = '0;
    overflow = 1'b0;
    result   = '0;
    case (op_q)
      2'b00: wide = a_ext + b_ext;
      2'b01: wide = a_ext - b_ext;
      2'b10: wide = b_ext - a_ext;
      default: begin
        wide = a_ext + b_ext;
        avg  = wide >>> 1;
      end
    endcase
    if (op_q == 2'b11) begin
      result = avg[DATA_W-1:0];
    end else begin
      overflow = (wide[DATA_W] != wide[DATA_W-1]);
      result   = wide[DATA_W-1:0];
      if (overflow && SAT)
        result = wide[DATA_W] ? DATA_MIN : DATA_MAX;
    end
  end

  // Move results forward: skid first, then fresh data; park fresh data in the
  // skid register while the destination is stalling
  always_comb begin
    s1_valid_d   = rd_en;
    s1_row_d     = row_q;
    s1_col_d     = col_q;
    skid_valid_d = skid_valid_q;
    skid_row_d   = skid_row_q;
    skid_col_d   = skid_col_q;
    skid_data_d  = skid_data_q;
    out_valid_d  = out_valid_q;
    out_row_d    = out_row_q;
    out_col_d    = out_col_q;
    out_data_d   = out_data_q;
    if (!stall) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_row_d    = skid_row_q;
        out_col_d    = skid_col_q;
        out_data_d   = skid_data_q;
        skid_valid_d = s1_valid_q;
        if (s1_valid_q) begin
          skid_row_d  = s1_row_q;
          skid_col_d  = s1_col_q;
          skid_data_d = result;
        end
      end else if (s1_valid_q) begin
        out_valid_d = 1'b1;
        out_row_d   = s1_row_q;
        out_col_d   = s1_col_q;
        out_data_d  = result;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (s1_valid_q) begin
      skid_valid_d = 1'b1;
      skid_row_d   = s1_row_q;
      skid_col_d   = s1_col_q;
      skid_data_d  = result;
    end
  end

  // Datapath and job registers; reset discards anything in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q         <= '0;
      m_dim_q      <= '0;
      n_dim_q      <= '0;
      row_q        <= '0;
      col_q        <= '0;
      err_q        <= 1'b0;
      ovf_q        <= 1'b0;
      s1_valid_q   <= 1'b0;
      s1_row_q     <= '0;
      s1_col_q     <= '0;
      skid_valid_q <= 1'b0;
      skid_row_q   <= '0;
      skid_col_q   <= '0;
      skid_data_q  <= '0;
      out_valid_q  <= 1'b0;
      out_row_q    <= '0;
      out_col_q    <= '0;
      out_data_q   <= '0;
    end else begin
      op_q         <= op_d;
      m_dim_q      <= m_dim_d;
      n_dim_q      <= n_dim_d;
      row_q        <= row_d;
      col_q        <= col_d;
      err_q        <= err_d;
      ovf_q        <= ovf_d;
      s1_valid_q   <= s1_valid_d;
      s1_row_q     <= s1_row_d;
      s1_col_q     <= s1_col_d;
      skid_valid_q <= skid_valid_d;
      skid_row_q   <= skid_row_d;
      skid_col_q   <= skid_col_d;
      skid_data_q  <= skid_data_d;
      out_valid_q  <= out_valid_d;
      out_row_q    <= out_row_d;
      out_col_q    <= out_col_d;
      out_data_q   <= out_data_d;
    end
  end

  assign bus.busy    = (state_q == RUN) || (state_q == DRAIN);
  assign bus.done    = (state_q == DONE);
  assign bus.err     = (state_q == DONE) && err_q;
  assign bus.ovf     = ovf_q;
  assign bus.rd_en   = rd_en;
  assign bus.rd_row  = row_q;
  assign bus.rd_col  = col_q;
  assign bus.wr_en   = out_valid_q;
  assign bus.wr_row  = out_row_q;
  assign bus.wr_col  = out_col_q;
  assign bus.wr_data = out_data_q;

endmodule

// File: tb/tb_matrix_addsub_stream.sv
// Directed bench for matrix_addsub_stream. Three engines (8-bit saturating,
// 8-bit wrapping, 32-bit default) share one stimulus stream and one pair of
// source memories; writes accepted by the engines are logged for checking.
module tb_matrix_addsub_stream;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start_in = 1'b0;
  logic [1:0] op_in = 2'b00;
  logic [7:0] m_in = 8'd0;
  logic [7:0] n_in = 8'd0;
  logic       ready_in = 1'b1;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] mem_a [4][4];
  logic [7:0] mem_b [4][4];
  logic [7:0]  a8s, b8s, a8w, b8w;
  logic [31:0] a32, b32;

  matrix_addsub_stream_if #(.DATA_W(8),  .DIM_W(8)) if8s ();
  matrix_addsub_stream_if #(.DATA_W(8),  .DIM_W(8)) if8w ();
  matrix_addsub_stream_if #(.DATA_W(32), .DIM_W(8)) if32 ();

  matrix_addsub_stream #(.DATA_W(8), .DIM_W(8), .SAT(1'b1)) u8s (
    .clk(clk), .reset(reset), .bus(if8s));
  matrix_addsub_stream #(.DATA_W(8), .DIM_W(8), .SAT(1'b0)) u8w (
    .clk(clk), .reset(reset), .bus(if8w));
  matrix_addsub_stream u32 (
    .clk(clk), .reset(reset), .bus(if32));

  assign if8s.start = start_in;  assign if8w.start = start_in;  assign if32.start = start_in;
  assign if8s.op = op_in;        assign if8w.op = op_in;        assign if32.op = op_in;
  assign if8s.m_dim = m_in;      assign if8w.m_dim = m_in;      assign if32.m_dim = m_in;
  assign if8s.n_dim = n_in;      assign if8w.n_dim = n_in;      assign if32.n_dim = n_in;
  assign if8s.wr_ready = ready_in; assign if8w.wr_ready = ready_in; assign if32.wr_ready = ready_in;
  assign if8s.a_data = a8s;  assign if8s.b_data = b8s;
  assign if8w.a_data = a8w;  assign if8w.b_data = b8w;
  assign if32.a_data = a32;  assign if32.b_data = b32;

  always #5 clk = ~clk;

  function automatic logic [31:0] sx8(input logic [7:0] v);
    return {{24{v[7]}}, v};
  endfunction

  // Source memories: data appears one cycle after the read strobe
  always @(posedge clk) begin
    if (if8s.rd_en) begin
      a8s <= mem_a[if8s.rd_row[1:0]][if8s.rd_col[1:0]];
      b8s <= mem_b[if8s.rd_row[1:0]][if8s.rd_col[1:0]];
    end
    if (if8w.rd_en) begin
      a8w <= mem_a[if8w.rd_row[1:0]][if8w.rd_col[1:0]];
      b8w <= mem_b[if8w.rd_row[1:0]][if8w.rd_col[1:0]];
    end
    if (if32.rd_en) begin
      a32 <= sx8(mem_a[if32.rd_row[1:0]][if32.rd_col[1:0]]);
      b32 <= sx8(mem_b[if32.rd_row[1:0]][if32.rd_col[1:0]]);
    end
  end

  // Write log, read count, stall count and stall-rule violations
  int          log_cnt = 0, rd_cnt = 0, stall_cnt = 0, viol_cnt = 0;
  logic [31:0] log_row [128];
  logic [31:0] log_col [128];
  logic [31:0] log_d8s [128];
  logic [31:0] log_d8w [128];
  logic [31:0] log_d32 [128];
  logic        prev_stall = 1'b0;
  logic [24:0] prev_word = '0;

  always @(negedge clk) begin
    #2;
    if (!reset) begin
      if (if8s.rd_en) rd_cnt <= rd_cnt + 1;
      if (if8s.wr_en && !if8s.wr_ready) stall_cnt <= stall_cnt + 1;
      if ((if8s.wr_en && !if8s.wr_ready && if8s.rd_en) ||
          (prev_stall && {if8s.wr_en, if8s.wr_row, if8s.wr_col, if8s.wr_data} != prev_word))
        viol_cnt <= viol_cnt + 1;
      prev_stall <= if8s.wr_en && !if8s.wr_ready;
      prev_word  <= {if8s.wr_en, if8s.wr_row, if8s.wr_col, if8s.wr_data};
      if (if8s.wr_en && if8s.wr_ready && log_cnt < 128) begin
        log_row[log_cnt] <= 32'(if8s.wr_row);
        log_col[log_cnt] <= 32'(if8s.wr_col);
        log_d8s[log_cnt] <= sx8(if8s.wr_data);
        log_d8w[log_cnt] <= sx8(if8w.wr_data);
        log_d32[log_cnt] <= if32.wr_data;
        log_cnt <= log_cnt + 1;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_cmp++;
    assert (observed === expected)
    else begin
      n_err++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] o, input int m, input int n);
    @(negedge clk);
    op_in    = o;
    m_in     = 8'(m);
    n_in     = 8'(n);
    start_in = 1'b1;
    @(negedge clk);
    start_in = 1'b0;
  endtask

  task automatic waitDone(input int c0, input int budget, input logic [31:0] pat,
                          output int cyc);
    int c;
    c = c0;
    ready_in = pat[5'(c % 32)];
    while (!if8s.done && c < budget) begin
      @(negedge clk);
      c++;
      ready_in = pat[5'(c % 32)];
    end
    checkOutput("done_seen", 32'(if8s.done), 1);
    cyc = c;
    ready_in = 1'b1;
  endtask

  task automatic fillMem(input int kind);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        case (kind)
          0: begin mem_a[r][c] = 8'(r*3 + c + 1); mem_b[r][c] = 8'(10*(r*3 + c + 1)); end
          1: begin mem_a[r][c] = 8'(r*4 + c);     mem_b[r][c] = 8'(3*(r*4 + c) + 5);  end
          default: begin mem_a[r][c] = 8'd100;    mem_b[r][c] = 8'd100;               end
        endcase
      end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cyc, base, rbase, sbase, vbase, c;

    // reset state
    repeat (3) @(negedge clk);
    checkOutput("rst_busy",   32'(if8s.busy), 0);
    checkOutput("rst_done",   32'(if8s.done), 0);
    checkOutput("rst_ovf",    32'(if8s.ovf), 0);
    checkOutput("rst_rd_en",  32'(if8s.rd_en), 0);
    checkOutput("rst_wr_en",  32'(if8s.wr_en), 0);
    checkOutput("rst_wr_data", 32'(if32.wr_data), 0);
    reset = 1'b0;

    // 2x3 A+B: 11..66 row-major, done at T+9
    fillMem(0);
    base = log_cnt; rbase = rd_cnt;
    applyStimulus(2'b00, 2, 3);
    checkOutput("t1_busy_rise", 32'(if8s.busy), 1);
    waitDone(1, 60, 32'hFFFF_FFFF, cyc);
    checkOutput("t1_done_cycle", 32'(cyc), 9);
    checkOutput("t1_busy_fall", 32'(if8s.busy), 0);
    checkOutput("t1_err", 32'(if8s.err), 0);
    checkOutput("t1_ovf", 32'(if8s.ovf), 0);
    checkOutput("t1_writes", 32'(log_cnt - base), 6);
    checkOutput("t1_reads", 32'(rd_cnt - rbase), 6);
    for (int i = 0; i < 6; i++) begin
      checkOutput("t1_row", log_row[base+i], 32'(i / 3));
      checkOutput("t1_col", log_col[base+i], 32'(i % 3));
      checkOutput("t1_d8", log_d8s[base+i], 32'(11*(i+1)));
      checkOutput("t1_d32", log_d32[base+i], 32'(11*(i+1)));
    end

    // back-to-back 2x3 again with a start pulsed while busy (ignored)
    base = log_cnt;
    applyStimulus(2'b00, 2, 3);
    @(negedge clk);
    op_in = 2'b01; m_in = 8'd1; n_in = 8'd1; start_in = 1'b1;
    @(negedge clk);
    start_in = 1'b0;
    waitDone(3, 60, 32'hFFFF_FFFF, cyc);
    checkOutput("t2_done_cycle", 32'(cyc), 9);
    checkOutput("t2_writes", 32'(log_cnt - base), 6);
    for (int i = 0; i < 6; i++)
      checkOutput("t2_d8", log_d8s[base+i], 32'(11*(i+1)));

    // 1x1 100+100: saturate 127, wrap -56, 32-bit 200
    fillMem(2);
    base = log_cnt;
    applyStimulus(2'b00, 1, 1);
    waitDone(1, 60, 32'hFFFF_FFFF, cyc);
    checkOutput("t3_done_cycle", 32'(cyc), 4);
    checkOutput("t3_sat", log_d8s[base], 32'd127);
    checkOutput("t3_wrap", log_d8w[base], 32'hFFFF_FFC8);
    checkOutput("t3_d32", log_d32[base], 32'd200);
    checkOutput("t3_ovf_sat", 32'(if8s.ovf), 1);
    checkOutput("t3_ovf_wrap", 32'(if8w.ovf), 1);
    checkOutput("t3_ovf_32", 32'(if32.ovf), 0);

    // 1x1 -128 - 1: saturate -128, wrap 127
    mem_a[0][0] = 8'h80; mem_b[0][0] = 8'd1;
    base = log_cnt;
    applyStimulus(2'b01, 1, 1);
    waitDone(1, 60, 32'hFFFF_FFFF, cyc);
    checkOutput("t4_sat", log_d8s[base], 32'hFFFF_FF80);
    checkOutput("t4_wrap", log_d8w[base], 32'd127);
    checkOutput("t4_d32", log_d32[base], 32'hFFFF_FF7F);
    checkOutput("t4_ovf", 32'(if8s.ovf), 1);

    // 1x2 average: (-3+0)>>>1 = -2, (127+127)>>>1 = 127, never overflows
    mem_a[0][0] = 8'hFD; mem_b[0][0] = 8'd0;
    mem_a[0][1] = 8'd127; mem_b[0][1] = 8'd127;
    base = log_cnt;
    applyStimulus(2'b11, 1, 2);
    waitDone(1, 60, 32'hFFFF_FFFF, cyc);
    checkOutput("t5_avg0", log_d8s[base], 32'hFFFF_FFFE);
    checkOutput("t5_avg1", log_d8s[base+1], 32'd127);
    checkOutput("t5_avg1_wrap", log_d8w[base+1], 32'd127);
    checkOutput("t5_avg0_32", log_d32[base], 32'hFFFF_FFFE);
    checkOutput("t5_ovf", 32'(if8s.ovf), 0);

    // 4x4 B-A = 2k+5 with wr_ready toggling
    fillMem(1);
    base = log_cnt; rbase = rd_cnt; sbase = stall_cnt; vbase = viol_cnt;
    applyStimulus(2'b10, 4, 4);
    waitDone(1, 300, 32'hD6B5_9E3A, cyc);
    checkOutput("t6_writes", 32'(log_cnt - base), 16);
    checkOutput("t6_reads", 32'(rd_cnt - rbase), 16);
    checkOutput("t6_stall_rules", 32'(viol_cnt - vbase), 0);
    checkOutput("t6_done_cycle", 32'(cyc), 32'(19 + stall_cnt - sbase));
    for (int i = 0; i < 16; i++) begin
      checkOutput("t6_row", log_row[base+i], 32'(i / 4));
      checkOutput("t6_col", log_col[base+i], 32'(i % 4));
      checkOutput("t6_data", log_d8s[base+i], 32'(2*i + 5));
    end

    // zero dimension: done and err together next cycle, no traffic
    base = log_cnt; rbase = rd_cnt;
    applyStimulus(2'b00, 0, 5);
    checkOutput("t7_done", 32'(if8s.done), 1);
    checkOutput("t7_err", 32'(if8s.err), 1);
    checkOutput("t7_busy", 32'(if8s.busy), 0);
    waitDone(1, 10, 32'hFFFF_FFFF, cyc);
    checkOutput("t7_done_cycle", 32'(cyc), 1);
    repeat (3) @(negedge clk);
    checkOutput("t7_done_pulse", 32'(if8s.done), 0);
    checkOutput("t7_no_reads", 32'(rd_cnt - rbase), 0);
    checkOutput("t7_no_writes", 32'(log_cnt - base), 0);

    // reset in the middle of a saturating 3x3 job after four writes
    fillMem(2);
    base = log_cnt;
    applyStimulus(2'b00, 3, 3);
    c = 0;
    while ((log_cnt - base) < 4 && c < 50) begin
      @(negedge clk);
      c++;
    end
    checkOutput("t8_four_writes", 32'(log_cnt - base), 4);
    checkOutput("t8_pre_ovf", 32'(if8s.ovf), 1);
    checkOutput("t8_pre_wr_en", 32'(if8s.wr_en), 1);
    checkOutput("t8_pre_data", sx8(if8s.wr_data), 32'd127);
    checkOutput("t8_row3", log_row[base+3], 32'd1);
    checkOutput("t8_col3", log_col[base+3], 32'd0);
    reset = 1'b1;
    #1;
    checkOutput("t8_busy", 32'(if8s.busy), 0);
    checkOutput("t8_done", 32'(if8s.done), 0);
    checkOutput("t8_err", 32'(if8s.err), 0);
    checkOutput("t8_ovf", 32'(if8s.ovf), 0);
    checkOutput("t8_rd_en", 32'(if8s.rd_en), 0);
    checkOutput("t8_rd_addr", {16'd0, if8s.rd_row, if8s.rd_col}, 0);
    checkOutput("t8_wr_en", 32'(if8s.wr_en), 0);
    checkOutput("t8_wr_addr", {16'd0, if8s.wr_row, if8s.wr_col}, 0);
    checkOutput("t8_wr_data", 32'(if8s.wr_data), 0);
    @(negedge clk);
    reset = 1'b0;

    // 1x2 job after reset: 5+6 = 11, -7-8 = -15
    mem_a[0][0] = 8'd5;  mem_b[0][0] = 8'd6;
    mem_a[0][1] = 8'hF9; mem_b[0][1] = 8'hF8;
    base = log_cnt;
    applyStimulus(2'b00, 1, 2);
    waitDone(1, 60, 32'hFFFF_FFFF, cyc);
    checkOutput("t9_done_cycle", 32'(cyc), 5);
    checkOutput("t9_writes", 32'(log_cnt - base), 2);
    checkOutput("t9_d0", log_d8s[base], 32'd11);
    checkOutput("t9_d1", log_d8s[base+1], 32'hFFFF_FFF1);
    checkOutput("t9_col1", log_col[base+1], 32'd1);
    checkOutput("t9_ovf", 32'(if8s.ovf), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
